// File: rtl/cdb_pkg.sv
// Shared CDB definitions.
//   CDB_TAG_W / CDB_DATA_W : default ROB tag and result widths on the bus
//   cdb_pkt_t              : one bus packet {tag, data}
//   NUM_FU                 : number of requesters seen by cdb_arbiter
package cdb_pkg;

   localparam int CDB_TAG_W  = 4;
   localparam int CDB_DATA_W = 32;
   localparam int NUM_FU     = 3;

   typedef struct packed {
      logic [CDB_TAG_W-1:0]  tag;
      logic [CDB_DATA_W-1:0] data;
   } cdb_pkt_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular FIFO with occupancy counter.
//   clk, rst : clock, async active-high reset (pointers and count only)
//   push     : write din at tail (caller guarantees not full)
//   pop      : retire head (caller guarantees not empty)
//   flush    : empty the FIFO at the next edge, overriding push/pop
//   din      : entry to write
//   head     : entry at the read pointer
//   full     : count == DEPTH
//   empty    : count == 0
//   count    : occupancy, 0..DEPTH
module sync_fifo #(
   parameter int WIDTH = 36,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;

   // Storage is not reset; its contents are meaningless while count is 0.
   always_ff @(posedge clk) begin
      if (push && !flush)
         mem[wr_ptr] <= din;
   end

   // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/cdb_result_queue.sv
// Per-FU result queue feeding the common data bus.
//   clk, rst          : clock, async active-high reset
//   stall_i           : global stall; blocks pops, not pushes
//   flush_i           : discard all queued results at the next edge
//   fu_valid_i/tag/data : completed FU result
//   fu_ready_o        : queue not full
//   cdb_req_o         : request to the arbiter while non-empty
//   cdb_grant_i       : this FU's arbiter select bit
//   cdb_valid_o/tag/data : broadcast; tag/data are zero when not valid
//   count_o           : occupancy
//   overflow_o        : sticky, a push was attempted while full
module cdb_result_queue
   import cdb_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int TAG_W  = CDB_TAG_W,
   parameter int DATA_W = CDB_DATA_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stall_i,
   input  logic                   flush_i,
   input  logic                   fu_valid_i,
   input  logic [TAG_W-1:0]       fu_tag_i,
   input  logic [DATA_W-1:0]      fu_data_i,
   output logic                   fu_ready_o,
   output logic                   cdb_req_o,
   input  logic                   cdb_grant_i,
   output logic                   cdb_valid_o,
   output logic [TAG_W-1:0]       cdb_tag_o,
   output logic [DATA_W-1:0]      cdb_data_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   overflow_o
);

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
   } pkt_t;

   pkt_t in_pkt;
   pkt_t head_pkt;
   logic full;
   logic empty;
   logic push;
   logic pop;

   assign in_pkt.tag  = fu_tag_i;
   assign in_pkt.data = fu_data_i;

   // No full-bypass: a pop in the same cycle does not make room for a push.
   assign fu_ready_o = ~full;
   assign push       = fu_valid_i & ~full;
   assign cdb_req_o  = ~empty;
   assign pop        = cdb_req_o & cdb_grant_i & ~stall_i;

   sync_fifo #(
      .WIDTH ($bits(pkt_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (flush_i),
      .din   (in_pkt),
      .head  (head_pkt),
      .full  (full),
      .empty (empty),
      .count (count_o)
   );

   // A flush still lets the already-granted head go out this cycle.
   always_comb begin
      cdb_valid_o = pop;
      cdb_tag_o   = '0;
      cdb_data_o  = '0;
      if (pop) begin
         cdb_tag_o  = head_pkt.tag;
         cdb_data_o = head_pkt.data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         overflow_o <= 1'b0;
      else if (fu_valid_i && full)
         overflow_o <= 1'b1;
   end

endmodule

// File: tb/tb_cdb_result_queue.sv
module tb_cdb_result_queue;
   import cdb_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i, flush_i, fu_valid_i, cdb_grant_i;
   logic [3:0]  fu_tag_i;
   logic [31:0] fu_data_i;
   logic        fu_ready_o, cdb_req_o, cdb_valid_o, overflow_o;
   logic [3:0]  cdb_tag_o;
   logic [31:0] cdb_data_o;
   logic [2:0]  count_o;

   always #5 clk = ~clk;

   cdb_result_queue #(.DEPTH(DEPTH), .TAG_W(4), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
      .fu_valid_i(fu_valid_i), .fu_tag_i(fu_tag_i), .fu_data_i(fu_data_i),
      .fu_ready_o(fu_ready_o), .cdb_req_o(cdb_req_o), .cdb_grant_i(cdb_grant_i),
      .cdb_valid_o(cdb_valid_o), .cdb_tag_o(cdb_tag_o), .cdb_data_o(cdb_data_o),
      .count_o(count_o), .overflow_o(overflow_o)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: an ordered list of pending results plus a sticky flag.
   cdb_pkt_t q[$];
   logic     m_ovf;
   logic     m_rdy, m_pop;

   typedef struct {
      logic        grant, valid;
      logic [3:0]  tag;
      logic [31:0] data;
      logic        e_req, e_rdy;
      logic [2:0]  e_cnt;
      logic        e_cv;
      logic [3:0]  e_ct;
      logic [31:0] e_cd;
      logic        e_ovf;
   } vec_t;

   vec_t tbl[15];

   function automatic vec_t mk(logic g, logic v, logic [3:0] t, logic [31:0] d,
                               logic req, logic rdy, logic [2:0] cnt, logic cv,
                               logic [3:0] ct, logic [31:0] cd, logic ovf);
      vec_t r;
      r.grant = g; r.valid = v; r.tag = t; r.data = d;
      r.e_req = req; r.e_rdy = rdy; r.e_cnt = cnt; r.e_cv = cv;
      r.e_ct = ct; r.e_cd = cd; r.e_ovf = ovf;
      return r;
   endfunction

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic st, input logic fl, input logic v,
                         input logic [3:0] t, input logic [31:0] d, input logic g);
      stall_i = st; flush_i = fl; fu_valid_i = v;
      fu_tag_i = t; fu_data_i = d; cdb_grant_i = g;
   endtask

   // Apply inputs for the current cycle and compare every output to the model.
   task automatic drive_and_check(input string name, input logic st, input logic fl,
                                  input logic v, input logic [3:0] t,
                                  input logic [31:0] d, input logic g);
      cdb_pkt_t h;
      set_in(st, fl, v, t, d, g);
      #1;
      m_rdy = (q.size() < DEPTH);
      m_pop = (q.size() > 0) && g && !st;
      h = m_pop ? q[0] : '0;
      cmp({name, ".ready"}, 64'(fu_ready_o), 64'(m_rdy));
      cmp({name, ".req"},   64'(cdb_req_o),  64'(q.size() > 0));
      cmp({name, ".valid"}, 64'(cdb_valid_o), 64'(m_pop));
      cmp({name, ".tag"},   64'(cdb_tag_o),  64'(h.tag));
      cmp({name, ".data"},  64'(cdb_data_o), 64'(h.data));
      cmp({name, ".count"}, 64'(count_o),    64'(q.size()));
      cmp({name, ".ovf"},   64'(overflow_o), 64'(m_ovf));
   endtask

   task automatic tick();
      cdb_pkt_t p;
      @(posedge clk);
      if (!m_rdy && fu_valid_i) m_ovf = 1'b1;
      if (flush_i) q.delete();
      else begin
         if (m_pop) void'(q.pop_front());
         if (fu_valid_i && m_rdy) begin
            p.tag = fu_tag_i; p.data = fu_data_i;
            q.push_back(p);
         end
      end
      #1;
   endtask

   task automatic cyc(input string name, input logic st, input logic fl, input logic v,
                      input logic [3:0] t, input logic [31:0] d, input logic g);
      drive_and_check(name, st, fl, v, t, d, g);
      tick();
   endtask

   task automatic do_reset();
      set_in(0, 0, 0, 4'h0, 32'h0, 0);
      rst = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      q.delete();
      m_ovf = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      set_in(0, 0, 0, 4'h0, 32'h0, 0);
      m_ovf = 1'b0; m_rdy = 1'b1; m_pop = 1'b0;
      #2;
      do_reset();
      cmp("reset.count", 64'(count_o), 64'd0);
      cmp("reset.ready", 64'(fu_ready_o), 64'd1);

      // Basic flow, grant-while-empty, fill, overflow, in-order drain with wrap.
      tbl[0]  = mk(0, 1, 4'd3, 32'hDEADBEEF, 0, 1, 3'd0, 0, 4'd0, 32'h0, 0);
      tbl[1]  = mk(0, 0, 4'd0, 32'h0,        1, 1, 3'd1, 0, 4'd0, 32'h0, 0);
      tbl[2]  = mk(1, 0, 4'd0, 32'h0,        1, 1, 3'd1, 1, 4'd3, 32'hDEADBEEF, 0);
      tbl[3]  = mk(0, 0, 4'd0, 32'h0,        0, 1, 3'd0, 0, 4'd0, 32'h0, 0);
      tbl[4]  = mk(1, 0, 4'd0, 32'h0,        0, 1, 3'd0, 0, 4'd0, 32'h0, 0);
      tbl[5]  = mk(0, 1, 4'd1, 32'hA5A50001, 0, 1, 3'd0, 0, 4'd0, 32'h0, 0);
      tbl[6]  = mk(0, 1, 4'd2, 32'hA5A50002, 1, 1, 3'd1, 0, 4'd0, 32'h0, 0);
      tbl[7]  = mk(0, 1, 4'd3, 32'hA5A50003, 1, 1, 3'd2, 0, 4'd0, 32'h0, 0);
      tbl[8]  = mk(0, 1, 4'd4, 32'hA5A50004, 1, 1, 3'd3, 0, 4'd0, 32'h0, 0);
      tbl[9]  = mk(0, 1, 4'd5, 32'hA5A50005, 1, 0, 3'd4, 0, 4'd0, 32'h0, 0);
      tbl[10] = mk(1, 0, 4'd0, 32'h0,        1, 0, 3'd4, 1, 4'd1, 32'hA5A50001, 1);
      tbl[11] = mk(1, 0, 4'd0, 32'h0,        1, 1, 3'd3, 1, 4'd2, 32'hA5A50002, 1);
      tbl[12] = mk(1, 0, 4'd0, 32'h0,        1, 1, 3'd2, 1, 4'd3, 32'hA5A50003, 1);
      tbl[13] = mk(1, 0, 4'd0, 32'h0,        1, 1, 3'd1, 1, 4'd4, 32'hA5A50004, 1);
      tbl[14] = mk(0, 0, 4'd0, 32'h0,        0, 1, 3'd0, 0, 4'd0, 32'h0, 1);
      for (int i = 0; i < 15; i++) begin
         string n;
         n = $sformatf("vec%0d", i);
         set_in(0, 0, tbl[i].valid, tbl[i].tag, tbl[i].data, tbl[i].grant);
         #1;
         cmp({n, ".req"},   64'(cdb_req_o),   64'(tbl[i].e_req));
         cmp({n, ".ready"}, 64'(fu_ready_o),  64'(tbl[i].e_rdy));
         cmp({n, ".count"}, 64'(count_o),     64'(tbl[i].e_cnt));
         cmp({n, ".valid"}, 64'(cdb_valid_o), 64'(tbl[i].e_cv));
         cmp({n, ".tag"},   64'(cdb_tag_o),   64'(tbl[i].e_ct));
         cmp({n, ".data"},  64'(cdb_data_o),  64'(tbl[i].e_cd));
         cmp({n, ".ovf"},   64'(overflow_o),  64'(tbl[i].e_ovf));
         @(posedge clk); #1;
      end
      // Table left the queue empty with overflow set; mirror that in the model.
      q.delete();
      m_ovf = 1'b1;

      // Asynchronous reset mid-cycle with two entries and a live grant.
      cyc("rst.p0", 0, 0, 1, 4'd7, 32'h00000077, 0);
      cyc("rst.p1", 0, 0, 1, 4'd8, 32'h00000088, 0);
      drive_and_check("rst.pre", 0, 0, 0, 4'd0, 32'h0, 1);
      #1 rst = 1'b1;
      #1;
      cmp("rst.async.valid", 64'(cdb_valid_o), 64'd0);
      cmp("rst.async.tag",   64'(cdb_tag_o),   64'd0);
      cmp("rst.async.data",  64'(cdb_data_o),  64'd0);
      cmp("rst.async.req",   64'(cdb_req_o),   64'd0);
      cmp("rst.async.count", 64'(count_o),     64'd0);
      cmp("rst.async.ready", 64'(fu_ready_o),  64'd1);
      cmp("rst.async.ovf",   64'(overflow_o),  64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      q.delete();
      m_ovf = 1'b0;
      drive_and_check("rst.post", 0, 0, 0, 4'd0, 32'h0, 1);
      cmp("rst.post.novalid", 64'(cdb_valid_o), 64'd0);
      tick();

      // Stall: grant held for three stalled cycles, then two back-to-back pops.
      do_reset();
      cyc("st.p0", 0, 0, 1, 4'd9, 32'h99990000, 0);
      cyc("st.p1", 0, 0, 1, 4'd10, 32'hAAAA0000, 0);
      for (int i = 0; i < 3; i++) begin
         drive_and_check($sformatf("st.hold%0d", i), 1, 0, 0, 4'd0, 32'h0, 1);
         cmp("st.hold.count", 64'(count_o), 64'd2);
         cmp("st.hold.req",   64'(cdb_req_o), 64'd1);
         cmp("st.hold.valid", 64'(cdb_valid_o), 64'd0);
         tick();
      end
      drive_and_check("st.rel0", 0, 0, 0, 4'd0, 32'h0, 1);
      cmp("st.rel0.tag", 64'(cdb_tag_o), 64'd9);
      tick();
      drive_and_check("st.rel1", 0, 0, 0, 4'd0, 32'h0, 1);
      cmp("st.rel1.tag", 64'(cdb_tag_o), 64'd10);
      tick();

      // Continuous push+pop at count 2 keeps occupancy and order.
      do_reset();
      cyc("pp.p0", 0, 0, 1, 4'd1, 32'h10, 0);
      cyc("pp.p1", 0, 0, 1, 4'd2, 32'h20, 0);
      for (int i = 0; i < 6; i++) begin
         drive_and_check($sformatf("pp%0d", i), 0, 0, 1, 4'(i + 3), 32'((i + 3) * 16), 1);
         cmp("pp.count", 64'(count_o), 64'd2);
         cmp("pp.tag",   64'(cdb_tag_o), 64'(i + 1));
         tick();
      end

      // Flush with same-cycle grant and push.
      do_reset();
      cyc("fl.p0", 0, 0, 1, 4'd11, 32'hB0, 0);
      cyc("fl.p1", 0, 0, 1, 4'd12, 32'hC0, 0);
      cyc("fl.p2", 0, 0, 1, 4'd13, 32'hD0, 0);
      drive_and_check("fl.go", 0, 1, 1, 4'd14, 32'hE0, 1);
      cmp("fl.go.valid", 64'(cdb_valid_o), 64'd1);
      cmp("fl.go.tag",   64'(cdb_tag_o),   64'd11);
      tick();
      drive_and_check("fl.after", 0, 0, 0, 4'd0, 32'h0, 1);
      cmp("fl.after.count", 64'(count_o), 64'd0);
      cmp("fl.after.req",   64'(cdb_req_o), 64'd0);
      cmp("fl.after.valid", 64'(cdb_valid_o), 64'd0);
      tick();

      // Randomized traffic against the model.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         cyc($sformatf("rnd%0d", i),
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 19) == 0),
             ($urandom_range(0, 9) < 6), 4'($urandom), 32'($urandom),
             ($urandom_range(0, 1) == 1));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
